// File: rtl/data_mem_access_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : data_mem_access_if
//  Brief    : Bundles the execute-side request, data-memory bus and
//             writeback-side result signals of the memory-access stage.
//  Revision : 1.0  initial release
// ============================================================================
interface data_mem_access_if;
    // Execute -> stage
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg_in;
    logic        xfer_byte;
    logic [63:0] alu_addr;
    logic [63:0] store_data;
    // Stage <-> data memory
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    // Stage -> writeback
    logic        wb_valid;
    logic        wb_ready;
    logic        MemtoReg;
    logic [63:0] dm_read_data;
    logic [63:0] dm_address;
    logic        mem_err;

    // The stage itself
    modport slave (
        input  req_valid, MemRead, MemWrite, MemtoReg_in, xfer_byte,
        input  alu_addr, store_data, mem_ack, mem_rdata, wb_ready,
        output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output wb_valid, MemtoReg, dm_read_data, dm_address, mem_err
    );

    // The environment driving the stage (execute, memory and writeback)
    modport master (
        output req_valid, MemRead, MemWrite, MemtoReg_in, xfer_byte,
        output alu_addr, store_data, mem_ack, mem_rdata, wb_ready,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  wb_valid, MemtoReg, dm_read_data, dm_address, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_access.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : data_mem_access
//  Brief    : Memory-access pipeline stage. Accepts one op at a time, runs a
//             req/ack transaction with data memory for loads/stores, and hands
//             the load data and ALU result to writeback.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    data_mem_access_if.slave   bus
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q,        state_d;
    logic [7:0]  cnt_q,          cnt_d;
    logic        is_load_q,      is_load_d;
    logic        is_byte_q,      is_byte_d;
    logic [2:0]  lane_q,         lane_d;
    logic        mem_we_q,       mem_we_d;
    logic [63:0] mem_addr_q,     mem_addr_d;
    logic [63:0] mem_wdata_q,    mem_wdata_d;
    logic [7:0]  mem_be_q,       mem_be_d;
    logic        memtoreg_q,     memtoreg_d;
    logic [63:0] dm_read_data_q, dm_read_data_d;
    logic [63:0] dm_address_q,   dm_address_d;
    logic        mem_err_q,      mem_err_d;

    logic [63:0] w_rdata_shifted;
    logic [7:0]  w_cnt_inc;

    // Selected byte lane of the returned doubleword sits in bits [7:0]
    assign w_rdata_shifted = bus.mem_rdata >> {lane_q, 3'b000};
    assign w_cnt_inc       = cnt_q + 8'd1;

    // Next-state and result computation for the three-state access FSM
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        is_load_d      = is_load_q;
        is_byte_d      = is_byte_q;
        lane_d         = lane_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_be_d       = mem_be_q;
        memtoreg_d     = memtoreg_q;
        dm_read_data_d = dm_read_data_q;
        dm_address_d   = dm_address_q;
        mem_err_d      = mem_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    dm_address_d   = bus.alu_addr;
                    memtoreg_d     = bus.MemtoReg_in;
                    dm_read_data_d = 64'd0;
                    cnt_d          = 8'd0;
                    state_d        = RESP;
                    if (bus.MemRead && bus.MemWrite) begin
                        // Contradictory op: abort without touching memory
                        mem_err_d = 1'b1;
                    end else if (!bus.MemRead && !bus.MemWrite) begin
                        // ALU op: result forwarded as dm_address only
                        mem_err_d = 1'b0;
                    end else if (!bus.xfer_byte && (bus.alu_addr[2:0] != 3'd0)) begin
                        // Doubleword access must be naturally aligned
                        mem_err_d = 1'b1;
                    end else begin
                        mem_err_d  = 1'b0;
                        state_d    = ACCESS;
                        is_load_d  = bus.MemRead;
                        is_byte_d  = bus.xfer_byte;
                        lane_d     = bus.alu_addr[2:0];
                        mem_we_d   = bus.MemWrite;
                        mem_addr_d = {bus.alu_addr[63:3], 3'b000};
                        if (bus.xfer_byte) begin
                            mem_be_d    = 8'h01 << bus.alu_addr[2:0];
                            mem_wdata_d = {8{bus.store_data[7:0]}};
                        end else begin
                            mem_be_d    = 8'hFF;
                            mem_wdata_d = bus.store_data;
                        end
                    end
                end
            end

            ACCESS: begin
                if (bus.mem_ack) begin
                    // Ack wins even on the cycle the timeout would expire
                    state_d = RESP;
                    if (!is_load_q) begin
                        dm_read_data_d = 64'd0;
                    end else if (is_byte_q) begin
                        dm_read_data_d = {56'd0, w_rdata_shifted[7:0]};
                    end else begin
                        dm_read_data_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == C_TIMEOUT) begin
                        state_d        = RESP;
                        mem_err_d      = 1'b1;
                        dm_read_data_d = 64'd0;
                    end
                end
            end

            RESP: begin
                if (bus.wb_ready) begin
                    state_d   = IDLE;
                    mem_err_d = 1'b0;
                    cnt_d     = 8'd0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            is_load_q      <= 1'b0;
            is_byte_q      <= 1'b0;
            lane_q         <= 3'd0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 64'd0;
            mem_wdata_q    <= 64'd0;
            mem_be_q       <= 8'd0;
            memtoreg_q     <= 1'b0;
            dm_read_data_q <= 64'd0;
            dm_address_q   <= 64'd0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            is_load_q      <= is_load_d;
            is_byte_q      <= is_byte_d;
            lane_q         <= lane_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_be_q       <= mem_be_d;
            memtoreg_q     <= memtoreg_d;
            dm_read_data_q <= dm_read_data_d;
            dm_address_q   <= dm_address_d;
            mem_err_q      <= mem_err_d;
        end
    end

    // Handshake outputs decode straight from the state register so an
    // asynchronous reset withdraws mem_req/wb_valid without a clock edge
    assign bus.req_ready    = (state_q == IDLE);
    assign bus.mem_req      = (state_q == ACCESS);
    assign bus.wb_valid     = (state_q == RESP);
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_be       = mem_be_q;
    assign bus.MemtoReg     = memtoreg_q;
    assign bus.dm_read_data = dm_read_data_q;
    assign bus.dm_address   = dm_address_q;
    assign bus.mem_err      = mem_err_q;

endmodule
`default_nettype wire
